uart_tx_arbiter: RTL
====================

// Module: uart_tx_arbiter
// PURPOSE
// - Shares one UART transmitter between two message requesters (e.g. user message path and chatbot reply path).
// - Arbitrates round-robin and drives the transmitter's 64-bit message/load interface.
// - Waits for frame completion, acks the winner, then enforces an inter-message gap.
// - Aborts and reports an error if the transmitter never completes.
// PARAMETERS
// - MSG_W           64      message width in bits
// - TIMEOUT_CYCLES  200000  max cycles in WAIT_DONE before abort; >=1; counter width = $clog2(TIMEOUT_CYCLES+1)
// - GAP_CYCLES      16      idle cycles forced after each ack/err; 0 = no gap state
// PORTS
// - clk_Arbiter    in   1      single clock, rising edge
// - Reset_Arbiter  in   1      asynchronous, active-low reset
// - req_0, req_1   in   1      level request; held until ack_x/err_x
// - msg_0, msg_1   in   MSG_W  message; valid while req_x high
// - tx_done        in   1      1-cycle pulse from UART TX at end of last stop bit
// - message_out    out  MSG_W  message to UART TX; registered
// - load_message   out  1      1-cycle load strobe to UART TX
// - grant          out  2      one-hot current owner; 2'b00 when none
// - ack_0, ack_1   out  1      1-cycle pulse: frame sent
// - err_0, err_1   out  1      1-cycle pulse: frame aborted on timeout
// - arb_busy       out  1      high whenever state != IDLE
// BEHAVIOUR
// - Reset (Reset_Arbiter=0, async): state=IDLE; message_out=0; load_message=0; grant=00; ack_x=0; err_x=0;
//   arb_busy=0; timeout/gap counters=0; last_grant=1, so requester 0 wins the first tie.
// - FSM states: IDLE, LOAD, WAIT_DONE, GAP.
// - IDLE: requests are sampled only here.
//   - One request high: that requester wins.
//   - Both high: winner = requester != last_grant.
//   - On a win: capture msg_w into message_out, set grant one-hot, last_grant=w, go to LOAD.
// - LOAD: load_message=1 for exactly this one cycle; counter cleared; go to WAIT_DONE.
//   - Latency: req seen high at IDLE edge n -> load_message high in cycle n+1.
// - WAIT_DONE: counter increments each cycle.
//   - tx_done=1: next cycle ack_w=1 for one cycle; grant->00; go to GAP.
//   - Counter reaches TIMEOUT_CYCLES: next cycle err_w=1 for one cycle; grant->00; go to GAP.
//   - tx_done and timeout in the same cycle: tx_done wins (ack, no err).
// - GAP: stays GAP_CYCLES cycles, then IDLE. With GAP_CYCLES=0, GAP is skipped (WAIT_DONE -> IDLE).
//   - No request is granted during GAP, so a requester dropping req after its ack is never re-granted stale.
// - message_out holds its last value outside LOAD..WAIT_DONE; it changes only at grant.
// - ack_x/err_x: never both high; only for the granted index; one pulse per grant.
// - tx_done outside WAIT_DONE: ignored.
// - req_w dropped mid-transfer: ignored; the transfer completes and ack/err still pulse.
// - msg_w changing after grant: no effect.
// - Reset mid-operation: immediate return to reset values.
//   - No pending ack/err and no repeated load after reset release; last_grant re-initialised.
// - Counter arithmetic is unsigned, saturating at TIMEOUT_CYCLES (no wrap).
// TESTING
// - Single: req_0=1, msg_0=64'h48454C4C4F000000; tx_done 10 cycles after load
//   -> load_message 1 cycle after req, message_out=msg_0, grant=01, ack_0 pulse, then GAP_CYCLES idle.
// - Tie/round-robin: req_0=req_1=1 from reset
//   -> order 0,1,0,1 over four frames; grant alternates 01,10; each ack matches grant.
// - Timeout: TIMEOUT_CYCLES=50, req_1=1, no tx_done
//   -> err_1 pulse 51 cycles after load; no ack_1; back to IDLE after the gap.
// - Collision: tx_done on the same cycle the counter hits TIMEOUT_CYCLES -> ack only, err_x stays 0.
// - Reset mid-frame: Reset_Arbiter low during WAIT_DONE
//   -> all outputs 0 asynchronously; after release with req_0=1, a fresh single load and ack_0.
// - Noise: tx_done pulses in IDLE/GAP, msg_0 changed after grant
//   -> no state change; message_out keeps the captured value.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two message requesters.
// Handles load strobe, completion wait with timeout abort, ack/err pulses and a post-frame gap.

module uart_tx_arbiter_chk (
  input logic       clk,
  input logic       rst_n,
  input logic [1:0] grant,
  input logic [1:0] ack,
  input logic [1:0] err,
  input logic       load
);

  a_ack_err_excl: assert property (@(posedge clk) disable iff (!rst_n) !((|ack) && (|err)));
  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant));
  a_ack_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(ack));
  a_err_onehot:   assert property (@(posedge clk) disable iff (!rst_n) $onehot0(err));
  a_load_owned:   assert property (@(posedge clk) disable iff (!rst_n) load |-> (grant != 2'b00));

endmodule

module uart_tx_arbiter #(
  parameter int MSG_W          = 64,
  parameter int TIMEOUT_CYCLES = 200000,
  parameter int GAP_CYCLES     = 16
) (
  input  logic             clk_Arbiter,
  input  logic             Reset_Arbiter,
  input  logic             req_0,
  input  logic             req_1,
  input  logic [MSG_W-1:0] msg_0,
  input  logic [MSG_W-1:0] msg_1,
  input  logic             tx_done,
  output logic [MSG_W-1:0] message_out,
  output logic             load_message,
  output logic [1:0]       grant,
  output logic             ack_0,
  output logic             ack_1,
  output logic             err_0,
  output logic             err_1,
  output logic             arb_busy
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : GAP_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  // A zero-length gap sends the frame-finished path straight back to IDLE.
  localparam state_e ST_AFTER = (GAP_CYCLES > 0) ? ST_GAP : ST_IDLE;

  state_e           state_q, state_d;
  logic [MSG_W-1:0] msg_q, msg_d;
  logic             load_q, load_d;
  logic [1:0]       grant_q, grant_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       err_q, err_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [GAP_W-1:0] gap_q, gap_d;

  logic             win_s;
  logic [CNT_W-1:0] cnt_inc_s;

  // Winner selection and saturating timeout increment.
  always_comb begin
    win_s     = 1'b0;
    cnt_inc_s = cnt_q;
    if (req_0 && req_1) begin
      win_s = ~last_q;
    end else if (req_1) begin
      win_s = 1'b1;
    end else begin
      win_s = 1'b0;
    end
    if (cnt_q == CNT_MAX) begin
      cnt_inc_s = cnt_q;
    end else begin
      cnt_inc_s = cnt_q + CNT_ONE;
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    msg_d   = msg_q;
    load_d  = 1'b0;
    grant_d = grant_q;
    ack_d   = 2'b00;
    err_d   = 2'b00;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (req_0 || req_1) begin
          state_d = ST_LOAD;
          msg_d   = win_s ? msg_1 : msg_0;
          load_d  = 1'b1;
          grant_d = win_s ? 2'b10 : 2'b01;
          last_d  = win_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cnt_d   = {CNT_W{1'b0}};
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        cnt_d = cnt_inc_s;
        // Completion takes priority over a timeout landing on the same cycle.
        if (tx_done) begin
          ack_d   = grant_q;
          grant_d = 2'b00;
          gap_d   = {GAP_W{1'b0}};
          state_d = ST_AFTER;
        end else if (cnt_inc_s == CNT_MAX) begin
          err_d   = grant_q;
          grant_d = 2'b00;
          gap_d   = {GAP_W{1'b0}};
          state_d = ST_AFTER;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_GAP: begin
        if (gap_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = 2'b00;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk_Arbiter or negedge Reset_Arbiter) begin
    if (!Reset_Arbiter) begin
      state_q <= ST_IDLE;
      msg_q   <= {MSG_W{1'b0}};
      load_q  <= 1'b0;
      grant_q <= 2'b00;
      ack_q   <= 2'b00;
      err_q   <= 2'b00;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
      cnt_q   <= {CNT_W{1'b0}};
      gap_q   <= {GAP_W{1'b0}};
    end else begin
      state_q <= state_d;
      msg_q   <= msg_d;
      load_q  <= load_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
    end
  end

  assign message_out  = msg_q;
  assign load_message = load_q;
  assign grant        = grant_q;
  assign ack_0        = ack_q[0];
  assign ack_1        = ack_q[1];
  assign err_0        = err_q[0];
  assign err_1        = err_q[1];
  assign arb_busy     = busy_q;

  uart_tx_arbiter_chk u_chk (
    .clk   (clk_Arbiter),
    .rst_n (Reset_Arbiter),
    .grant (grant_q),
    .ack   (ack_q),
    .err   (err_q),
    .load  (load_q)
  );

endmodule
